fir_out_requant: RTL
====================

# fir_out_requant

Output stage placed directly after the 32-tap FIR filter. It takes the filter's full-precision 48-bit result stream and decimates it by a programmable factor. Each kept sample is rounded and saturated to a 24-bit signed word. Results are buffered in a small FIFO behind a ready/valid interface, because the filter's result port has no backpressure: this block must accept every filter output and absorb downstream stalls.

## Interface
Parameters:
- DECIM, 4: decimation factor, legal 1..16; keeps one of every DECIM input samples.
- SHIFT, 23: arithmetic right-shift applied before saturation, legal 0..40.
- OUT_W, 24: output word width, signed.
- FIFO_DEPTH, 8: output FIFO entries, power of two, ≥2.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- y_in  in  48  signed filter result.
- valid_in  in  1  y_in valid this cycle; always accepted, no ready returned.
- dout  out  OUT_W  signed requantized sample, head of FIFO.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  downstream accepts dout when dout_valid=1.
- clear  in  1  synchronous flush: same effect as reset, except on the parameters.
- sat_flag  out  1  sticky: some kept sample saturated.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.

## Operation
- Decimation counter phase (0..DECIM-1) advances on each valid_in and wraps to 0. A sample is kept when the phase is 0, so the first sample after reset or clear is kept.
- Stage 1 registers sum = sext49(y_in) + (SHIFT>0 ? 2^(SHIFT-1) : 0). The 49-bit width means the sum never wraps. Rounding is half-up toward +inf.
- Stage 2 computes q = sum >>> SHIFT (arithmetic).
  - If q > 2^(OUT_W-1)-1, the output is max and sat_flag is set.
  - If q < -2^(OUT_W-1), the output is min and sat_flag is set.
  - Otherwise the output is q[OUT_W-1:0].
- Stage 2 writes its result to the FIFO.
- FIFO write is allowed if the FIFO is not full, or if a read occurs in the same cycle. A read occurs when dout_valid & dout_ready.
- A write refused at full drops the sample and sets overflow. The FIFO contents are untouched.
- A simultaneous read and write at full is legal: the count is unchanged and nothing is dropped.
- The FIFO is show-ahead: dout is the oldest entry whenever dout_valid=1. dout must hold stable while dout_valid=1 and dout_ready=0.
- sat_flag and overflow stay set until reset or clear.
- Reset or clear (sys_rst_n=0 or clear=1 at an edge):
  - decimation phase goes to 0 and pipeline valids are cleared;
  - the FIFO is emptied;
  - dout_valid=0, dout=0, sat_flag=0, overflow=0.
  - The cycle's valid_in is ignored.
- Reset or clear mid-operation discards in-flight samples.

## Timing
- Latency: a kept sample with valid_in at edge N is written to the FIFO at edge N+2. It appears as dout_valid=1 after edge N+2 if the FIFO was empty. From there it is 3 register stages from input to output.
- Throughput: one input per cycle sustained. Output rate is 1/DECIM of the input rate.
- dout_ready=0 has no effect on input acceptance. Only FIFO capacity limits buffering.
- All outputs are registered and there is no combinational path from dout_ready to dout_valid.

## Structure
- Shared package fir_pkg holds:
  - constant FIR_OUT_W=48;
  - constant SAMPLE_W=24, the default OUT_W, which is also the filter input width;
  - a function sat_round(sum, shift, out_w) used in stage 2, so the bench's reference model uses the same definition.
- One sub-module is natural: sync_fifo, parameterized width/depth, show-ahead, with full/empty/count. Decimator and rounder stay in the top.

## Test plan
- DECIM=1, SHIFT=23, dout_ready=1:
  - y_in=2^22 gives dout=1.
  - 2^22-1 gives 0.
  - -2^22 gives 0.
  - -2^22-1 gives -1.
  - Each appears 3 cycles after input.
- Saturation: y_in=0x7FFF_FFFF_FFFF gives dout=0x7FFFFF and sat_flag=1. Then y_in=0x8000_0000_0000 gives 0x800000, with sat_flag still 1.
- DECIM=4, SHIFT=0, inputs 0..11 consecutive gives outputs 0, 4, 8 in order, then no further dout_valid.
- Backpressure: DECIM=1, FIFO_DEPTH=8, dout_ready=0, 9 samples 1..9:
  - dout_valid=1 with dout=1 held stable;
  - overflow=1 after the 9th sample;
  - releasing ready drains exactly 1..8.
- Full with simultaneous read/write: hold the FIFO full, then assert dout_ready=1 while streaming. Result: no drop, overflow stays 0, order preserved.
- Reset mid-stream: assert sys_rst_n=0 for 1 cycle while the FIFO holds 5 entries and stage 1/2 are occupied.
  - All outputs go to 0 and dout_valid=0 on the next cycle.
  - The next input is kept (phase 0).
  - The same check repeats with clear=1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR definitions: widths and the round/saturate reference function.
// Latency: none (package).
// Backpressure: n/a.
package fir_pkg;

  localparam int FIR_OUT_W = 48;
  localparam int SAMPLE_W  = 24;
  // One guard bit above the filter width, so adding the rounding constant never wraps.
  localparam int SUM_W     = FIR_OUT_W + 1;

  typedef struct packed {
    logic                 sat;
    logic [FIR_OUT_W-1:0] val;
  } sat_res_t;

  // Arithmetic shift of an already-rounded sum, clamped to a signed out_w-bit range.
  // val is the clamped result, sign-extended to FIR_OUT_W bits.
  function automatic sat_res_t sat_round(input logic signed [SUM_W-1:0] sum,
                                         input int shift,
                                         input int out_w);
    logic signed [SUM_W-1:0] q;
    logic signed [SUM_W-1:0] one;
    logic signed [SUM_W-1:0] maxv;
    logic signed [SUM_W-1:0] minv;
    sat_res_t                r;
    one   = SUM_W'(1);
    q     = sum >>> shift;
    maxv  = (one <<< (out_w - 1)) - one;
    minv  = ~maxv;
    r.sat = 1'b0;
    r.val = q[FIR_OUT_W-1:0];
    if (q > maxv) begin
      r.sat = 1'b1;
      r.val = maxv[FIR_OUT_W-1:0];
    end else if (q < minv) begin
      r.sat = 1'b1;
      r.val = minv[FIR_OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/count status.
// Latency: a write is visible at the head one edge later when the FIFO was empty.
// Backpressure: a write at full is refused unless a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr_vld,
  input  logic [WIDTH-1:0]         i_wr_dat,
  input  logic                     i_rd_rdy,
  output logic [WIDTH-1:0]         o_rd_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign w_rd    = i_rd_rdy & ~o_empty;
  // Freeing a slot in the same cycle makes room for the incoming word.
  assign w_wr    = i_wr_vld & (~o_full | w_rd);
  // Head is forced to zero while empty so a flushed FIFO presents 0.
  assign o_rd_dat = o_empty ? '0 : r_mem[r_rptr];

  // Storage array: written only on an accepted write, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_dat;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round half-up, saturate to OUT_W, buffer in a FIFO.
// Latency: kept sample at edge N is written to the FIFO at edge N+2 (3 register stages).
// Backpressure: input never stalls; a kept sample arriving at a full, unread FIFO is dropped and flagged.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 23,
  parameter int OUT_W      = SAMPLE_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic signed [FIR_OUT_W-1:0] y_in,
  input  logic                        valid_in,
  output logic signed [OUT_W-1:0]     dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  input  logic                        clear,
  output logic                        sat_flag,
  output logic                        overflow
);

  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
  // Half an output LSB, added before the shift for round-half-up.
  localparam logic [SUM_W-1:0] RND     = (SHIFT > 0) ? (SUM_W'(1) << RND_SH) : '0;

  logic [PH_W-1:0]         r_phase;
  logic                    r_s1_vld;
  logic signed [SUM_W-1:0] r_s1_sum;
  logic                    r_s2_vld;
  logic [OUT_W-1:0]        r_s2_dat;
  logic                    r_sat;
  logic                    r_ovf;

  logic                    w_flush;
  logic                    w_keep;
  sat_res_t                w_sr;
  logic                    w_full;
  logic                    w_empty;
  logic [CNT_W-1:0]        w_count;
  logic                    w_rd;
  logic                    w_drop;

  assign w_flush    = ~sys_rst_n | clear;
  assign w_keep     = valid_in & (r_phase == '0);
  assign w_sr       = sat_round(r_s1_sum, SHIFT, OUT_W);
  assign w_rd       = dout_ready & ~w_empty;
  assign w_drop     = r_s2_vld & w_full & ~w_rd;
  assign dout_valid = ~w_empty;
  assign sat_flag   = r_sat;
  assign overflow   = r_ovf;

  // Decimation phase: counts every valid input, sample kept at phase 0.
  always_ff @(posedge sys_clk) begin
    if (w_flush) begin
      r_phase <= '0;
    end else if (valid_in) begin
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
    end
  end

  // Stage 1: sign-extend and add the rounding constant.
  always_ff @(posedge sys_clk) begin
    if (w_flush) begin
      r_s1_vld <= 1'b0;
      r_s1_sum <= '0;
    end else begin
      r_s1_vld <= w_keep;
      if (w_keep) r_s1_sum <= $signed({y_in[FIR_OUT_W-1], y_in}) + $signed(RND);
    end
  end

  // Stage 2: shift and clamp; saturation is remembered until reset/clear.
  always_ff @(posedge sys_clk) begin
    if (w_flush) begin
      r_s2_vld <= 1'b0;
      r_s2_dat <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) r_s2_dat <= w_sr.val[OUT_W-1:0];
      r_sat    <= r_sat | (r_s1_vld & w_sr.sat);
    end
  end

  // Sticky record of any kept sample lost to a full FIFO.
  always_ff @(posedge sys_clk) begin
    if (w_flush) r_ovf <= 1'b0;
    else         r_ovf <= r_ovf | w_drop;
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_flush  (clear),
    .i_wr_vld (r_s2_vld),
    .i_wr_dat (r_s2_dat),
    .i_rd_rdy (dout_ready),
    .o_rd_dat (dout),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // Invariants: full flag tracks occupancy, and the clamped value always fits OUT_W.
  a_full_cnt: assert property (@(posedge sys_clk) w_full == (w_count == CNT_W'(FIFO_DEPTH)));
  a_fits: assert property (@(posedge sys_clk)
    !r_s1_vld || (w_sr.val == FIR_OUT_W'($signed(w_sr.val[OUT_W-1:0]))));

endmodule
